water_level_sensor_filter: RTL and testbench

//   Conditions three raw float-switch inputs (low/mid/high) into the 2-bit level code
//   {Bit1,Bit0} consumed by the 7-segment level decoder: 00 ERROR/CRIT, 01 LOW, 10 MIDDLE, 11 HIGH.

---
 rtl/water_level_pkg.sv | 38 +++
 rtl/sensor_debounce.sv | 47 ++++
 rtl/water_level_sensor_filter.sv | 138 +++++++++++++
 tb/tb_water_level_sensor_filter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/water_level_pkg.sv
// Shared definitions for the water level sensor filter: level codes, FSM states
// and the float-switch pattern classifier.
package water_level_pkg;

  localparam logic [1:0] LVL_CRIT = 2'b00;
  localparam logic [1:0] LVL_LOW  = 2'b01;
  localparam logic [1:0] LVL_MID  = 2'b10;
  localparam logic [1:0] LVL_HIGH = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } class_t;

  // Switches fill bottom-up, so only "thermometer" patterns are physically possible.
  function automatic class_t classify(input logic [2:0] hml);
    class_t c;
    c.valid = 1'b1;
    case (hml)
      3'b000:  c.code = LVL_CRIT;
      3'b001:  c.code = LVL_LOW;
      3'b011:  c.code = LVL_MID;
      3'b111:  c.code = LVL_HIGH;
      default: begin
        c.valid = 1'b0;
        c.code  = LVL_CRIT;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a saturating-run debouncer for one float switch.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/water_level_sensor_filter.sv
// Debounces the low/mid/high float switches, classifies them into a 2-bit level
// code and supervises impossible patterns with an INIT/RUN/FAULT state machine.
module water_level_sensor_filter
  import water_level_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FAULT_CYCLES    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sens_low,
  input  logic sens_mid,
  input  logic sens_high,
  input  logic clear_fault,
  output logic Bit1,
  output logic Bit0,
  output logic settled,
  output logic fault,
  output logic fault_sticky,
  output logic level_change
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int FW = $clog2(FAULT_CYCLES + 1);

  logic filt_low, filt_mid, filt_high;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_low (
    .clk(clk), .rst_n(rst_n), .raw(sens_low), .filt(filt_low)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mid (
    .clk(clk), .rst_n(rst_n), .raw(sens_mid), .filt(filt_mid)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_high (
    .clk(clk), .rst_n(rst_n), .raw(sens_high), .filt(filt_high)
  );

  state_e        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] incon_q, incon_d;
  logic          settled_q, settled_d;
  logic          fault_q, fault_d;
  logic          sticky_q, sticky_d;
  logic          lchg_q, lchg_d;
  logic          enter_fault;
  class_t        cls;

  always_comb begin
    cls         = classify({filt_high, filt_mid, filt_low});
    state_d     = state_q;
    code_d      = code_q;
    timer_d     = timer_q;
    incon_d     = incon_q;
    settled_d   = settled_q;
    sticky_d    = sticky_q;
    enter_fault = 1'b0;

    case (state_q)
      ST_INIT: begin
        code_d = LVL_CRIT;
        // Window covers the synchroniser plus one full debounce run.
        if (timer_q == TW'(DEBOUNCE_CYCLES + 2)) begin
          settled_d = 1'b1;
          if (cls.valid) begin
            state_d = ST_RUN;
          end else begin
            state_d     = ST_FAULT;
            enter_fault = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (cls.valid) begin
          code_d  = cls.code;
          incon_d = '0;
        end else if (incon_q == FW'(FAULT_CYCLES - 1)) begin
          state_d     = ST_FAULT;
          code_d      = LVL_CRIT;
          incon_d     = '0;
          enter_fault = 1'b1;
        end else begin
          incon_d = incon_q + FW'(1);
        end
      end
      ST_FAULT: begin
        code_d = LVL_CRIT;
        if (cls.valid) begin
          state_d = ST_RUN;
          code_d  = cls.code;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Entering FAULT takes priority over a simultaneous clear request.
    if (enter_fault) begin
      sticky_d = 1'b1;
    end else if (clear_fault && (state_q != ST_FAULT)) begin
      sticky_d = 1'b0;
    end

    fault_d = (state_d == ST_FAULT);
    lchg_d  = (state_q != ST_INIT) && (code_d != code_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      code_q    <= LVL_CRIT;
      timer_q   <= '0;
      incon_q   <= '0;
      settled_q <= 1'b0;
      fault_q   <= 1'b0;
      sticky_q  <= 1'b0;
      lchg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      timer_q   <= timer_d;
      incon_q   <= incon_d;
      settled_q <= settled_d;
      fault_q   <= fault_d;
      sticky_q  <= sticky_d;
      lchg_q    <= lchg_d;
    end
  end

  assign Bit1         = code_q[1];
  assign Bit0         = code_q[0];
  assign settled      = settled_q;
  assign fault        = fault_q;
  assign fault_sticky = sticky_q;
  assign level_change = lchg_q;

endmodule

// File: tb/tb_water_level_sensor_filter.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// sensor traffic compared every cycle against a window-based behavioural model.
module tb_water_level_sensor_filter;

  localparam int D = 4;
  localparam int F = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sens_low = 1'b0, sens_mid = 1'b0, sens_high = 1'b0;
  logic clear_fault = 1'b0;
  logic Bit1, Bit0, settled, fault, fault_sticky, level_change;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  water_level_sensor_filter #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .sens_low(sens_low), .sens_mid(sens_mid), .sens_high(sens_high),
    .clear_fault(clear_fault),
    .Bit1(Bit1), .Bit0(Bit0), .settled(settled), .fault(fault),
    .fault_sticky(fault_sticky), .level_change(level_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A switch's filtered value flips once the last D synchronised samples all disagree with it;
  // the synchronised sample seen at an edge is the raw value sampled two edges earlier.
  logic [D+1:0] hist [3];
  logic [2:0]   mf;
  logic [1:0]   m_code = 2'b00;
  bit           m_settled = 0, m_fault = 0, m_sticky = 0, m_lc = 0;
  int           m_edges = 0, m_bad = 0;
  logic [2:0]   pat, raw_v;
  logic [1:0]   prev;
  bit           ok, was_fault, was_settled, entered;

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '0;
    mf = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      mf = '0; m_code = 2'b00; m_settled = 0; m_fault = 0; m_sticky = 0; m_lc = 0;
      m_edges = 0; m_bad = 0;
    end else begin
      raw_v       = {sens_high, sens_mid, sens_low};
      pat         = mf;
      ok          = (pat == 3'b000) || (pat == 3'b001) || (pat == 3'b011) || (pat == 3'b111);
      was_fault   = m_fault;
      was_settled = m_settled;
      prev        = m_code;
      entered     = 0;
      if (m_edges < 1000) m_edges++;

      if (!m_settled) begin
        if (m_edges == D + 3) begin
          m_settled = 1;
          if (!ok) begin m_fault = 1; entered = 1; end
        end
      end else if (m_fault) begin
        if (ok) begin m_fault = 0; m_code = 2'($countones(pat)); end
      end else if (ok) begin
        m_bad = 0; m_code = 2'($countones(pat));
      end else begin
        m_bad++;
        if (m_bad == F) begin m_bad = 0; m_fault = 1; m_code = 2'b00; entered = 1; end
      end

      if (entered) m_sticky = 1;
      else if (clear_fault && !was_fault) m_sticky = 0;
      m_lc = was_settled && (m_code != prev);

      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][D:0], raw_v[i]};
        if (mf[i] ? (hist[i][D+1:2] == '0) : (&hist[i][D+1:2])) mf[i] = ~mf[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("code",         int'({Bit1, Bit0}), int'(m_code));
      check("settled",      int'(settled),      int'(m_settled));
      check("fault",        int'(fault),        int'(m_fault));
      check("fault_sticky", int'(fault_sticky), int'(m_sticky));
      check("level_change", int'(level_change), int'(m_lc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_hml(input logic [2:0] v);
    {sens_high, sens_mid, sens_low} = v;
  endtask

  function automatic logic [2:0] level_pat(input int n);
    case (n)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  initial begin
    // 1: reset release and settling window
    #1 rst_n = 1'b0;
    #2 cmp_en = 1'b1;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(6);
    check("s1_settled_e6", int'(settled), 0);
    wait_edges(1);
    check("s1_settled_e7", int'(settled), 1);
    wait_edges(3);
    check("s1_code", int'({Bit1, Bit0}), 0);
    check("s1_fault", int'(fault), 0);

    // 2: clean steps through the levels
    set_hml(3'b001);
    wait_edges(6);
    check("s2_code_e6", int'({Bit1, Bit0}), 0);
    wait_edges(1);
    check("s2_code_e7", int'({Bit1, Bit0}), 1);
    check("s2_lc_e7", int'(level_change), 1);
    wait_edges(1);
    check("s2_lc_e8", int'(level_change), 0);
    set_hml(3'b011);
    wait_edges(7);
    check("s2_code_mid", int'({Bit1, Bit0}), 2);
    set_hml(3'b111);
    wait_edges(7);
    check("s2_code_high", int'({Bit1, Bit0}), 3);

    // 4: impossible pattern, recovery, clear
    wait_edges(2);
    set_hml(3'b101);
    wait_edges(7);
    check("s4_code_e7", int'({Bit1, Bit0}), 3);
    check("s4_fault_e7", int'(fault), 0);
    wait_edges(1);
    check("s4_fault_e8", int'(fault), 1);
    check("s4_sticky_e8", int'(fault_sticky), 1);
    check("s4_code_e8", int'({Bit1, Bit0}), 0);
    set_hml(3'b111);
    wait_edges(7);
    check("s4_code_back", int'({Bit1, Bit0}), 3);
    check("s4_fault_back", int'(fault), 0);
    check("s4_sticky_back", int'(fault_sticky), 1);
    clear_fault = 1'b1;
    wait_edges(1);
    clear_fault = 1'b0;
    check("s4_sticky_clr", int'(fault_sticky), 0);

    // 5: clear colliding with fault entry, clear while faulted
    set_hml(3'b101);
    wait_edges(7);
    clear_fault = 1'b1;
    wait_edges(1);
    check("s5_fault", int'(fault), 1);
    check("s5_sticky_setwins", int'(fault_sticky), 1);
    wait_edges(2);
    check("s5_sticky_infault", int'(fault_sticky), 1);
    clear_fault = 1'b0;
    set_hml(3'b111);
    wait_edges(7);
    check("s5_fault_back", int'(fault), 0);
    check("s5_sticky_held", int'(fault_sticky), 1);
    clear_fault = 1'b1;
    wait_edges(1);
    clear_fault = 1'b0;

    // 3: glitch rejection versus a just-long-enough pulse
    set_hml(3'b001);
    wait_edges(8);
    check("s3_code_low", int'({Bit1, Bit0}), 1);
    set_hml(3'b011);
    wait_edges(3);
    set_hml(3'b001);
    wait_edges(8);
    check("s3_glitch", int'({Bit1, Bit0}), 1);
    set_hml(3'b011);
    wait_edges(4);
    set_hml(3'b001);
    wait_edges(3);
    check("s3_pulse4", int'({Bit1, Bit0}), 2);
    wait_edges(4);
    check("s3_pulse4_back", int'({Bit1, Bit0}), 1);
    wait_edges(4);

    // 6: asynchronous reset mid-debounce
    set_hml(3'b011);
    wait_edges(8);
    check("s6_code_mid", int'({Bit1, Bit0}), 2);
    set_hml(3'b111);
    wait_edges(2);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_code", int'({Bit1, Bit0}), 0);
    check("s6_rst_settled", int'(settled), 0);
    check("s6_rst_fault", int'(fault), 0);
    check("s6_rst_lc", int'(level_change), 0);
    set_hml(3'b000);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(6);
    check("s6_settled_e6", int'(settled), 0);
    wait_edges(1);
    check("s6_settled_e7", int'(settled), 1);
    check("s6_code_e7", int'({Bit1, Bit0}), 0);

    // Random traffic: mostly clean levels, some impossible patterns and short glitches
    repeat (80) begin
      if ($urandom_range(0, 9) < 6) set_hml(level_pat(int'($urandom_range(0, 3))));
      else set_hml(3'($urandom_range(0, 7)));
      repeat ($urandom_range(1, 12)) begin
        clear_fault = ($urandom_range(0, 7) == 0);
        wait_edges(1);
      end
    end
    clear_fault = 1'b0;
    wait_edges(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
